// File: rtl/cpu_seq_pkg.sv
// Shared types and constants for the RV32I multi-cycle control sequencer.
package cpu_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT,
        FAULT
    } state_e;

    typedef enum logic [3:0] {
        OP,
        OPIMM,
        LOAD,
        STORE,
        BRANCH,
        JAL,
        LUI,
        SYSTEM,
        ILLEGAL
    } opclass_e;

    // RV32I major opcodes (instr[6:0])
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Write-back source select
    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_IMM = 2'd3;

    // Classes whose ALU B operand is the immediate
    function automatic logic uses_imm(input opclass_e c);
        return (c == OPIMM) || (c == LOAD) || (c == STORE) || (c == LUI);
    endfunction

endpackage

// File: rtl/cpu_seq_if.sv
// Request/ready handshake bundle between the sequencer and the instruction
// and data memories.
interface cpu_seq_if;
    logic imem_req;
    logic imem_rdy;
    logic dmem_req;
    logic dmem_we;
    logic dmem_rdy;

    modport master (
        output imem_req,
        input  imem_rdy,
        output dmem_req,
        output dmem_we,
        input  dmem_rdy
    );

    modport slave (
        input  imem_req,
        output imem_rdy,
        input  dmem_req,
        input  dmem_we,
        output dmem_rdy
    );
endinterface

// File: rtl/cpu_seq_op_classify.sv
// Combinational RV32I opcode classifier, shared by sequencer and decoder.
module op_classify
    import cpu_seq_pkg::*;
(
    input  logic [6:0] i_opcode,
    output opclass_e   o_class
);

    // Map the major opcode onto its instruction class
    always_comb begin
        o_class = ILLEGAL;
        case (i_opcode)
            OPC_OP:     o_class = OP;
            OPC_OPIMM:  o_class = OPIMM;
            OPC_LOAD:   o_class = LOAD;
            OPC_STORE:  o_class = STORE;
            OPC_BRANCH: o_class = BRANCH;
            OPC_JAL:    o_class = JAL;
            OPC_LUI:    o_class = LUI;
            OPC_SYSTEM: o_class = SYSTEM;
            default:    o_class = ILLEGAL;
        endcase
    end

endmodule

// File: rtl/cpu_seq.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer with memory
// handshake timeout and retired-instruction counter.
module cpu_seq
    import cpu_seq_pkg::*;
#(
    parameter int TO_CYCLES = 16,
    parameter int CNT_W     = $clog2(TO_CYCLES)
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic        clr,
    input  logic [6:0]  opcode,
    input  logic        branch_taken,
    cpu_seq_if.master   mem,
    output logic        ir_load,
    output logic        pc_incr,
    output logic        pc_load,
    output logic        regw,
    output logic        imm,
    output logic [1:0]  wb_sel,
    output logic        busy,
    output logic        halted,
    output logic        fault,
    output logic [31:0] instret
);

    state_e             r_state;
    state_e             w_next;
    opclass_e           r_cls;
    opclass_e           w_dec_cls;
    logic [CNT_W-1:0]   r_wcnt;
    logic [31:0]        r_instret;
    logic               w_retire;
    logic               w_last_wait;

    op_classify u_classify (
        .i_opcode (opcode),
        .o_class  (w_dec_cls)
    );

    // Final permitted wait cycle: a missing rdy here means the memory is stuck
    assign w_last_wait = (r_wcnt == CNT_W'(TO_CYCLES - 1));

    // Next-state and Moore-style output decode; rdy-qualified pulses fire in
    // the accepting cycle so the IR/PC capture on the transition edge
    always_comb begin
        w_next       = r_state;
        w_retire     = 1'b0;
        mem.imem_req = 1'b0;
        mem.dmem_req = 1'b0;
        mem.dmem_we  = 1'b0;
        ir_load      = 1'b0;
        pc_incr      = 1'b0;
        pc_load      = 1'b0;
        regw         = 1'b0;
        imm          = 1'b0;
        wb_sel       = WB_ALU;
        case (r_state)
            IDLE: begin
                if (run) w_next = FETCH;
            end
            FETCH: begin
                mem.imem_req = 1'b1;
                if (mem.imem_rdy) begin
                    ir_load = 1'b1;
                    w_next  = DECODE;
                end else if (w_last_wait) begin
                    w_next = FAULT;
                end
            end
            DECODE: begin
                case (w_dec_cls)
                    SYSTEM:  w_next = HALT;
                    ILLEGAL: w_next = FAULT;
                    default: w_next = EXEC;
                endcase
            end
            EXEC: begin
                imm = uses_imm(r_cls);
                if (r_cls == LOAD || r_cls == STORE) begin
                    w_next = MEM;
                end else if (r_cls == BRANCH) begin
                    w_retire = 1'b1;
                    if (branch_taken) pc_load = 1'b1;
                    else              pc_incr = 1'b1;
                end else begin
                    w_next = WB;
                end
            end
            MEM: begin
                mem.dmem_req = 1'b1;
                mem.dmem_we  = (r_cls == STORE);
                if (mem.dmem_rdy) begin
                    if (r_cls == STORE) begin
                        w_retire = 1'b1;
                        pc_incr  = 1'b1;
                    end else begin
                        w_next = WB;
                    end
                end else if (w_last_wait) begin
                    w_next = FAULT;
                end
            end
            WB: begin
                regw     = 1'b1;
                w_retire = 1'b1;
                case (r_cls)
                    LOAD:    wb_sel = WB_MEM;
                    JAL:     wb_sel = WB_PC4;
                    LUI:     wb_sel = WB_IMM;
                    default: wb_sel = WB_ALU;
                endcase
                if (r_cls == JAL) pc_load = 1'b1;
                else              pc_incr = 1'b1;
            end
            HALT, FAULT: begin
                if (clr) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        // Retiring always chains straight into the next fetch when run is up
        if (w_retire) w_next = run ? FETCH : IDLE;
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Opcode class captured in DECODE and held until the instruction retires
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                 r_cls <= OP;
        else if (r_state == DECODE) r_cls <= w_dec_cls;
    end

    // Handshake wait counter: restarts on every state change, counts stalls
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_wcnt <= '0;
        else if (w_next != r_state)
            r_wcnt <= '0;
        else if (r_state == FETCH || r_state == MEM)
            r_wcnt <= r_wcnt + CNT_W'(1);
    end

    // Retired-instruction counter, free-running wrap
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)        r_instret <= '0;
        else if (w_retire) r_instret <= r_instret + 32'd1;
    end

    assign instret = r_instret;
    assign busy    = !(r_state == IDLE || r_state == HALT || r_state == FAULT);
    assign halted  = (r_state == HALT);
    assign fault   = (r_state == FAULT);

endmodule
